// File: rtl/ysyx_22040237_lsu_pkg.sv
// Shared types for the load/store unit: memory operation encoding, FSM
// states, access sizes, byte-enable constants and small decode helpers
// used by both the LSU top and its lane-alignment logic.
package ysyx_22040237_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    LB, LH, LW, LD,
    LBU, LHU, LWU,
    SB, SH, SW, SD
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_t;

  // Byte enables for an access of each size at lane 0.
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  function automatic lsu_size_t op_size(input lsu_op_t op);
    case (op)
      LH, LHU, SH: return SZ_H;
      LW, LWU, SW: return SZ_W;
      LD, SD:      return SZ_D;
      default:     return SZ_B;
    endcase
  endfunction

  function automatic logic op_is_load(input lsu_op_t op);
    return (op inside {LB, LH, LW, LD, LBU, LHU, LWU});
  endfunction

  function automatic logic op_is_store(input lsu_op_t op);
    return (op inside {SB, SH, SW, SD});
  endfunction

  function automatic logic op_is_signed(input lsu_op_t op);
    return (op inside {LB, LH, LW, LD});
  endfunction

  function automatic logic [7:0] size_mask(input lsu_size_t sz);
    case (sz)
      SZ_H:    return MASK_H;
      SZ_W:    return MASK_W;
      SZ_D:    return MASK_D;
      default: return MASK_B;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_if.sv
// Memory-side bus of the LSU: one request channel (valid/ready, doubleword
// aligned address, write enable, lane-shifted data, byte mask) and one
// response channel (valid, aligned read doubleword; no ready, the LSU
// always sinks a response while waiting for it).
//   master : the LSU (drives requests, receives responses)
//   slave  : the memory (receives requests, drives responses)
interface ysyx_22040237_lsu_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

endinterface

// File: rtl/ysyx_22040237_lsu_align.sv
// Purely combinational byte-lane logic of the LSU.
//   chk_op/chk_off -> chk_misalign : misalignment test for an incoming op
//   op/off/st_src  -> st_wen/st_wdata/st_wmask : store lane shift and mask
//   op/off/ld_raw  -> ld_data : load extract, truncate and sign/zero extend
// off is the byte offset inside the aligned doubleword (addr[2:0]).
module ysyx_22040237_lsu_align
  import ysyx_22040237_pkg::*;
(
  input  lsu_op_t     chk_op,
  input  logic [2:0]  chk_off,
  output logic        chk_misalign,
  input  lsu_op_t     op,
  input  logic [2:0]  off,
  input  logic [63:0] st_src,
  input  logic [63:0] ld_raw,
  output logic        st_wen,
  output logic [63:0] st_wdata,
  output logic [7:0]  st_wmask,
  output logic [63:0] ld_data
);

  logic [5:0]  bit_shift;
  logic [63:0] ld_shifted;
  logic        ld_sign;

  assign bit_shift = {off, 3'b000};

  // Only memory ops can be misaligned; bytes never are.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    chk_misalign = 1'b0;
    if (op_is_load(chk_op) || op_is_store(chk_op)) begin
      case (op_size(chk_op))
        SZ_H:    chk_misalign = chk_off[0] != 1'b0;
        SZ_W:    chk_misalign = chk_off[1:0] != 2'b00;
        SZ_D:    chk_misalign = chk_off != 3'b000;
        default: chk_misalign = 1'b0;
      endcase
    end
  end

  // Loads and non-memory ops present an idle write channel.
  always_comb begin
    st_wen   = op_is_store(op);
    st_wdata = '0;
    st_wmask = '0;
    if (st_wen) begin
      st_wdata = st_src << bit_shift;
      st_wmask = size_mask(op_size(op)) << off;
    end
  end

  assign ld_shifted = ld_raw >> bit_shift;

  always_comb begin
    ld_sign = 1'b0;
    ld_data = ld_shifted;
    case (op_size(op))
      SZ_B: begin
        ld_sign = op_is_signed(op) & ld_shifted[7];
        ld_data = {{56{ld_sign}}, ld_shifted[7:0]};
      end
      SZ_H: begin
        ld_sign = op_is_signed(op) & ld_shifted[15];
        ld_data = {{48{ld_sign}}, ld_shifted[15:0]};
      end
      SZ_W: begin
        ld_sign = op_is_signed(op) & ld_shifted[31];
        ld_data = {{32{ld_sign}}, ld_shifted[31:0]};
      end
      default: ld_data = ld_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit between execute and writeback.
//   clk, rst (async, active-low)
//   in_*   : execute-side result with valid/ready handshake
//   out_*  : writeback-side result with valid/ready handshake, plus a
//            misaligned-access flag
//   mem    : memory bus (ysyx_22040237_lsu_if.master)
// One transaction at a time: IDLE accepts, REQ issues the memory request,
// WAIT takes the first response, DONE holds the result until accepted.
// Non-memory ops and misaligned accesses go straight from IDLE to DONE.
module ysyx_22040237_lsu
  import ysyx_22040237_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  lsu_op_t          in_op,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [XLEN-1:0]  in_rd_data,
  input  logic [4:0]       in_rd_idx,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_rd_data,
  output logic [4:0]       out_rd_idx,
  output logic             out_misalign,

  ysyx_22040237_lsu_if.master mem
);

  lsu_state_t      state_q, state_d;

  logic [XLEN-1:0] pc_q;
  lsu_op_t         op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] result_q;
  logic            misalign_q;

  logic            accept;
  logic            in_is_mem;
  logic            in_misalign;
  logic [63:0]     ld_data;

  ysyx_22040237_lsu_align u_align (
    .chk_op       (in_op),
    .chk_off      (in_addr[2:0]),
    .chk_misalign (in_misalign),
    .op           (op_q),
    .off          (addr_q[2:0]),
    .st_src       (wdata_q),
    .ld_raw       (mem.mem_resp_rdata),
    .st_wen       (mem.mem_req_wen),
    .st_wdata     (mem.mem_req_wdata),
    .st_wmask     (mem.mem_req_wmask),
    .ld_data      (ld_data)
  );

  assign in_is_mem = op_is_load(in_op) || op_is_store(in_op);
  assign accept    = (state_q == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic. Responses are only looked at in WAIT, which is
  // entered the cycle after request acceptance, so early or stale
  // responses fall on the floor.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)          state_d = (!in_is_mem || in_misalign) ? DONE : REQ;
      REQ:  if (mem.mem_req_ready) state_d = WAIT;
      WAIT: if (mem.mem_resp_valid) state_d = DONE;
      DONE: if (out_ready)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    mem.mem_req_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready          = 1'b1;
      REQ:     mem.mem_req_valid = 1'b1;
      DONE:    out_valid         = 1'b1;
      default: ;
    endcase
  end

  // Transaction registers. The result is fixed on entry to DONE so every
  // out_* field stays stable however long writeback stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath registers are reset too, because every out_*/mem_req_* field must read 0 in reset.
      pc_q       <= '0;
      op_q       <= NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_idx_q   <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else if (accept) begin
      pc_q       <= in_pc;
      op_q       <= in_op;
      addr_q     <= in_addr;
      wdata_q    <= in_wdata;
      rd_idx_q   <= in_rd_idx;
      misalign_q <= in_is_mem && in_misalign;
      // Non-memory ops pass the ALU result through; memory ops start at 0
      // and a misaligned one keeps it.
      result_q   <= in_is_mem ? '0 : in_rd_data;
    end else if ((state_q == WAIT) && mem.mem_resp_valid) begin
      result_q   <= op_is_load(op_q) ? ld_data : '0;
    end
  end

  assign mem.mem_req_addr = {addr_q[XLEN-1:3], 3'b000};

  assign out_pc       = pc_q;
  assign out_rd_data  = result_q;
  assign out_rd_idx   = rd_idx_q;
  assign out_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Directed self-checking bench for ysyx_22040237_lsu. Inputs change and
// outputs are observed on the falling clock edge.
module tb_ysyx_22040237_lsu;
  import ysyx_22040237_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  lsu_op_t     in_op;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [63:0] in_rd_data;
  logic [4:0]  in_rd_idx;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_rd_data;
  logic [4:0]  out_rd_idx;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  ysyx_22040237_lsu_if mem_bus ();

  ysyx_22040237_lsu #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_op        (in_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd_data   (in_rd_data),
    .in_rd_idx    (in_rd_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_rd_data  (out_rd_data),
    .out_rd_idx   (out_rd_idx),
    .out_misalign (out_misalign),
    .mem          (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents one transaction for a single cycle; returns on the falling
  // edge after acceptance.
  task automatic issue(input lsu_op_t op, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rd_data, input logic [4:0] idx, input logic [63:0] pc);
    in_op      = op;
    in_addr    = addr;
    in_wdata   = wdata;
    in_rd_data = rd_data;
    in_rd_idx  = idx;
    in_pc      = pc;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_op      = NONE;
  endtask

  // Load with an immediately ready memory answering one cycle later.
  task automatic run_load(input string tag, input lsu_op_t op, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp_addr,
                          input logic [63:0] exp_data);
    mem_bus.mem_req_ready = 1'b1;
    out_ready = 1'b1;
    issue(op, addr, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555, 5'd3, 64'h2000);
    check({tag, ".req_valid"}, mem_bus.mem_req_valid, 1);
    check({tag, ".req_addr"}, mem_bus.mem_req_addr, exp_addr);
    check({tag, ".wen"}, mem_bus.mem_req_wen, 0);
    check({tag, ".wmask"}, mem_bus.mem_req_wmask, 0);
    @(negedge clk);
    check({tag, ".wait_out_valid"}, out_valid, 0);
    check({tag, ".wait_req_valid"}, mem_bus.mem_req_valid, 0);
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_rdata = rdata;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".rd_data"}, out_rd_data, exp_data);
    check({tag, ".rd_idx"}, out_rd_idx, 5'd3);
    check({tag, ".misalign"}, out_misalign, 0);
    @(negedge clk);
    check({tag, ".back_idle"}, in_ready, 1);
  endtask

  task automatic run_store(input string tag, input lsu_op_t op, input logic [63:0] addr,
                           input logic [63:0] src, input logic [63:0] exp_addr,
                           input logic [63:0] exp_wdata, input logic [7:0] exp_wmask);
    mem_bus.mem_req_ready = 1'b1;
    out_ready = 1'b1;
    issue(op, addr, src, 64'h5555, 5'd7, 64'h3000);
    check({tag, ".req_valid"}, mem_bus.mem_req_valid, 1);
    check({tag, ".req_addr"}, mem_bus.mem_req_addr, exp_addr);
    check({tag, ".wen"}, mem_bus.mem_req_wen, 1);
    check({tag, ".wdata"}, mem_bus.mem_req_wdata, exp_wdata);
    check({tag, ".wmask"}, mem_bus.mem_req_wmask, exp_wmask);
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".rd_data"}, out_rd_data, 0);
    @(negedge clk);
    check({tag, ".back_idle"}, in_ready, 1);
  endtask

  task automatic run_misalign(input string tag, input lsu_op_t op, input logic [63:0] addr);
    mem_bus.mem_req_ready = 1'b1;
    out_ready = 1'b0;
    issue(op, addr, 64'h1234, 64'h9999, 5'd2, 64'h4000);
    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".misalign"}, out_misalign, 1);
    check({tag, ".rd_data"}, out_rd_data, 0);
    check({tag, ".req_valid"}, mem_bus.mem_req_valid, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".req_valid_after"}, mem_bus.mem_req_valid, 0);
    check({tag, ".back_idle"}, in_ready, 1);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_op = NONE;
    in_addr = '0;
    in_wdata = '0;
    in_rd_data = '0;
    in_rd_idx = '0;
    out_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.req_valid", mem_bus.mem_req_valid, 0);
    check("rst.misalign", out_misalign, 0);
    check("rst.rd_data", out_rd_data, 0);
    check("rst.req_addr", mem_bus.mem_req_addr, 0);
    check("rst.wmask", mem_bus.mem_req_wmask, 0);
    rst = 1'b1;
    @(negedge clk);

    // Pass-through: result one cycle after acceptance, no memory traffic.
    issue(NONE, 64'h0, 64'h0, 64'h1234, 5'd5, 64'h100);
    check("pass.out_valid", out_valid, 1);
    check("pass.rd_data", out_rd_data, 64'h1234);
    check("pass.rd_idx", out_rd_idx, 5'd5);
    check("pass.pc", out_pc, 64'h100);
    check("pass.req_valid", mem_bus.mem_req_valid, 0);
    check("pass.in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("pass.done_out_valid", out_valid, 0);
    check("pass.done_in_ready", in_ready, 1);

    // Loads: every size, signed and unsigned, at non-zero lane offsets.
    run_load("lb",  LB,  64'h8000_0003, 64'h0000_0000_8000_0000, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    run_load("lbu", LBU, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h8000_0000, 64'h0000_0000_0000_0080);
    run_load("lh",  LH,  64'h8000_0002, 64'h1111_2222_8001_3333, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_load("lhu", LHU, 64'h8000_0002, 64'h1111_2222_8001_3333, 64'h8000_0000, 64'h0000_0000_0000_8001);
    run_load("lw",  LW,  64'h8000_0004, 64'h8765_4321_0000_0000, 64'h8000_0000, 64'hFFFF_FFFF_8765_4321);
    run_load("lwu", LWU, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h8000_0000, 64'h0000_0000_8765_4321);
    run_load("ld",  LD,  64'h8000_0008, 64'hFEDC_BA98_7654_3210, 64'h8000_0008, 64'hFEDC_BA98_7654_3210);

    // Stores: lane shift and byte mask, result 0.
    run_store("sh", SH, 64'h8000_0006, 64'h1111_2222_3333_ABCD, 64'h8000_0000, 64'hABCD_0000_0000_0000, 8'hC0);
    run_store("sb", SB, 64'h8000_0007, 64'h0000_0000_0000_00A5, 64'h8000_0000, 64'hA500_0000_0000_0000, 8'h80);
    run_store("sd", SD, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);

    // Misaligned accesses never reach memory.
    run_misalign("mis_lw", LW, 64'h8000_0002);
    run_misalign("mis_ld", LD, 64'h8000_0004);
    run_misalign("mis_sh", SH, 64'h8000_0001);

    // Back-pressure on both sides; an early response during REQ is ignored
    // and a new input during DONE is not accepted.
    mem_bus.mem_req_ready = 1'b0;
    out_ready = 1'b0;
    issue(SW, 64'h8000_0004, 64'h0000_0000_CAFE_BABE, 64'h77, 5'd9, 64'h300);
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_rdata = 64'h0123_0123_0123_0123;
    for (int i = 0; i < 4; i++) begin
      check("bp.req_valid", mem_bus.mem_req_valid, 1);
      check("bp.req_addr", mem_bus.mem_req_addr, 64'h8000_0000);
      check("bp.wdata", mem_bus.mem_req_wdata, 64'hCAFE_BABE_0000_0000);
      check("bp.wmask", mem_bus.mem_req_wmask, 8'hF0);
      check("bp.wen", mem_bus.mem_req_wen, 1);
      check("bp.in_ready", in_ready, 0);
      check("bp.out_valid", out_valid, 0);
      @(negedge clk);
    end
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_req_ready = 1'b1;
    check("bp.req_still_valid", mem_bus.mem_req_valid, 1);
    @(negedge clk);
    mem_bus.mem_req_ready = 1'b0;
    check("bp.wait_out_valid", out_valid, 0);
    check("bp.wait_req_valid", mem_bus.mem_req_valid, 0);
    mem_bus.mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    in_op = NONE;
    in_pc = 64'h999;
    in_rd_data = 64'h4444;
    in_rd_idx = 5'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp.out_valid", out_valid, 1);
      check("bp.rd_data", out_rd_data, 0);
      check("bp.pc", out_pc, 64'h300);
      check("bp.rd_idx", out_rd_idx, 5'd9);
      check("bp.done_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.end_in_ready", in_ready, 1);
    check("bp.end_out_valid", out_valid, 0);

    // Reset during WAIT, response arriving after release.
    mem_bus.mem_req_ready = 1'b1;
    issue(LD, 64'h8000_0010, 64'h0, 64'h0, 5'd4, 64'h400);
    @(negedge clk);
    check("rmid.wait_req_valid", mem_bus.mem_req_valid, 0);
    check("rmid.wait_in_ready", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    check("rmid.async_in_ready", in_ready, 1);
    check("rmid.async_out_valid", out_valid, 0);
    check("rmid.async_pc", out_pc, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_bus.mem_resp_valid = 1'b1;
    mem_bus.mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    mem_bus.mem_resp_valid = 1'b0;
    check("rmid.stale_out_valid", out_valid, 0);
    check("rmid.stale_in_ready", in_ready, 1);
    check("rmid.stale_rd_data", out_rd_data, 0);
    @(negedge clk);
    check("rmid.later_out_valid", out_valid, 0);

    // Normal operation resumes.
    issue(NONE, 64'h0, 64'h0, 64'hBEEF, 5'd6, 64'h500);
    check("recover.out_valid", out_valid, 1);
    check("recover.rd_data", out_rd_data, 64'hBEEF);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
